// File: rtl/demux4x32_buf.sv
// 1-to-4 buffered demultiplexer: one producer feeds four single-entry holding registers,
// each drained by its own valid/ready consumer. It also keeps a wrapping accept counter.
module demux4x32_buf #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             CLRN,
  input  logic [WIDTH-1:0] D,
  input  logic [1:0]       S,
  input  logic             IN_VALID,
  output logic             IN_READY,
  output logic [WIDTH-1:0] Y0,
  output logic [WIDTH-1:0] Y1,
  output logic [WIDTH-1:0] Y2,
  output logic [WIDTH-1:0] Y3,
  output logic [3:0]       OUT_VALID,
  input  logic [3:0]       OUT_READY,
  output logic [CNT_W-1:0] COUNT
);

  logic [WIDTH-1:0] y_reg [4];
  logic             valid_reg [4];
  logic [CNT_W-1:0] count_reg;
  logic             accept;
  logic [3:0]       load;
  logic [3:0]       valid_vec;

  assign valid_vec = {valid_reg[3], valid_reg[2], valid_reg[1], valid_reg[0]};

  // A full channel can still take a word in the same cycle its consumer drains it.
  assign IN_READY = CLRN & (~valid_vec[S] | OUT_READY[S]);
  assign accept   = IN_VALID & IN_READY;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_chan
      assign load[gi] = accept & (S == 2'(gi));

      always_ff @(posedge CLK or negedge CLRN) begin
        if (!CLRN) begin
          y_reg[gi]     <= '0;
          valid_reg[gi] <= 1'b0;
        end else begin
          if (load[gi]) begin
            y_reg[gi]     <= D;
            valid_reg[gi] <= 1'b1;
          end else if (OUT_READY[gi]) begin
            valid_reg[gi] <= 1'b0;
          end
        end
      end
    end
  endgenerate

  always_ff @(posedge CLK or negedge CLRN) begin
    if (!CLRN) begin
      count_reg <= '0;
    end else if (accept) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign Y0        = y_reg[0];
  assign Y1        = y_reg[1];
  assign Y2        = y_reg[2];
  assign Y3        = y_reg[3];
  assign OUT_VALID = valid_vec;
  assign COUNT     = count_reg;

endmodule

// File: tb/tb_demux4x32_buf.sv
// Self-checking bench for demux4x32_buf: directed scenarios plus random traffic, checked by a
// per-channel scoreboard of expected words and a behavioural occupancy/counter model.
module tb_demux4x32_buf;

  logic        CLK = 1'b0;
  logic        CLRN;
  logic [31:0] D;
  logic [1:0]  S;
  logic        IN_VALID;
  logic        IN_READY;
  logic [31:0] Y0, Y1, Y2, Y3;
  logic [3:0]  OUT_VALID;
  logic [3:0]  OUT_READY;
  logic [15:0] COUNT;

  // Second instance with a 4-bit counter, driven in parallel, to exercise wrap-around.
  logic        in_ready_b;
  logic [31:0] y0_b, y1_b, y2_b, y3_b;
  logic [3:0]  valid_b;
  logic [3:0]  count_b;

  demux4x32_buf #(.WIDTH(32), .CNT_W(16)) dut (
    .CLK(CLK), .CLRN(CLRN), .D(D), .S(S), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .Y0(Y0), .Y1(Y1), .Y2(Y2), .Y3(Y3), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
    .COUNT(COUNT)
  );

  demux4x32_buf #(.WIDTH(32), .CNT_W(4)) dut_w4 (
    .CLK(CLK), .CLRN(CLRN), .D(D), .S(S), .IN_VALID(IN_VALID), .IN_READY(in_ready_b),
    .Y0(y0_b), .Y1(y1_b), .Y2(y2_b), .Y3(y3_b), .OUT_VALID(valid_b), .OUT_READY(OUT_READY),
    .COUNT(count_b)
  );

  always #5 CLK = ~CLK;

  int          total = 0;
  int          bad   = 0;
  int          delivered = 0;
  logic [31:0] exp_q [4][$];
  logic [31:0] last_word [4];
  logic [31:0] model_count;
  logic [31:0] ydut [4];
  logic [31:0] ydut_b [4];

  assign ydut[0] = Y0;
  assign ydut[1] = Y1;
  assign ydut[2] = Y2;
  assign ydut[3] = Y3;
  assign ydut_b[0] = y0_b;
  assign ydut_b[1] = y1_b;
  assign ydut_b[2] = y2_b;
  assign ydut_b[3] = y3_b;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < 4; i++) begin
      exp_q[i].delete();
      last_word[i] = '0;
    end
    model_count = '0;
  endtask

  // Monitor: at each falling edge the inputs and outputs for the coming rising edge are stable.
  always @(negedge CLK) begin : mon
    logic        mrdy;
    logic [31:0] w;
    mrdy = CLRN && ((exp_q[S].size() == 0) || OUT_READY[S]);
    chk("in_ready", IN_READY, mrdy);
    chk("in_ready_w4", in_ready_b, mrdy);
    chk("count", COUNT, model_count % 65536);
    chk("count_w4", count_b, model_count % 16);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("out_valid%0d", i), OUT_VALID[i], exp_q[i].size() != 0);
      chk($sformatf("out_valid_w4_%0d", i), valid_b[i], exp_q[i].size() != 0);
      chk($sformatf("y%0d_value", i), ydut[i], last_word[i]);
      chk($sformatf("y%0d_value_w4", i), ydut_b[i], last_word[i]);
    end
    if (CLRN) begin
      for (int i = 0; i < 4; i++) begin
        if (OUT_VALID[i] && OUT_READY[i]) begin
          chk($sformatf("drain%0d_expected", i), exp_q[i].size() != 0, 1);
          if (exp_q[i].size() != 0) begin
            w = exp_q[i].pop_front();
            chk($sformatf("drain%0d_data", i), ydut[i], w);
            delivered++;
          end
        end
      end
      if (IN_VALID && mrdy) begin
        exp_q[S].push_back(D);
        last_word[S] = D;
        model_count  = model_count + 1;
      end
    end
  end

  task automatic drive(input logic v, input logic [1:0] s, input logic [31:0] d,
                       input logic [3:0] r);
    IN_VALID  = v;
    S         = s;
    D         = d;
    OUT_READY = r;
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  logic [31:0] fill_vals [4];

  initial begin
    clear_model();
    CLRN = 1'b0;
    drive(1'b0, 2'd0, 32'd0, 4'd0);
    repeat (2) @(posedge CLK);
    #1;
    chk("reset_out_valid", OUT_VALID, 4'b0000);
    chk("reset_count", COUNT, 16'd0);
    chk("reset_in_ready", IN_READY, 1'b0);
    CLRN = 1'b1;

    // Basic routing
    drive(1'b1, 2'd2, 32'hDEADBEEF, 4'b0000);
    step();
    drive(1'b0, 2'd0, 32'd0, 4'b0000);
    chk("route_y2", Y2, 32'hDEADBEEF);
    chk("route_valid", OUT_VALID, 4'b0100);
    chk("route_count", COUNT, 16'd1);
    chk("route_y0", Y0, 32'd0);
    chk("route_y1", Y1, 32'd0);
    chk("route_y3", Y3, 32'd0);

    // Backpressure on channel 1, then redirect to channel 3
    drive(1'b1, 2'd1, 32'h11111111, 4'b0000);
    step();
    drive(1'b1, 2'd1, 32'h22222222, 4'b0000);
    #1;
    chk("bp_in_ready_full", IN_READY, 1'b0);
    step();
    chk("bp_y1_held", Y1, 32'h11111111);
    drive(1'b1, 2'd3, 32'h33333333, 4'b0000);
    #1;
    chk("bp_in_ready_other", IN_READY, 1'b1);
    step();
    chk("bp_y3", Y3, 32'h33333333);
    chk("bp_valid", OUT_VALID, 4'b1110);

    // Streaming through channel 0
    for (int k = 1; k <= 20; k++) begin
      drive(1'b1, 2'd0, 32'(k), 4'b0001);
      #1;
      chk("stream_in_ready", IN_READY, 1'b1);
      step();
      chk("stream_y0", Y0, 32'(k));
      chk("stream_valid0", OUT_VALID[0], 1'b1);
    end

    // Parallel drain of all four channels
    drive(1'b0, 2'd0, 32'd0, 4'b1111);
    step();
    chk("pd_empty_first", OUT_VALID, 4'b0000);
    for (int c = 0; c < 4; c++) begin
      fill_vals[c] = $urandom;
      drive(1'b1, 2'(c), fill_vals[c], 4'b0000);
      step();
    end
    chk("pd_full", OUT_VALID, 4'b1111);
    drive(1'b0, 2'd0, 32'd0, 4'b1111);
    step();
    chk("pd_valid", OUT_VALID, 4'b0000);
    chk("pd_y0", Y0, fill_vals[0]);
    chk("pd_y1", Y1, fill_vals[1]);
    chk("pd_y2", Y2, fill_vals[2]);
    chk("pd_y3", Y3, fill_vals[3]);

    // Asynchronous reset with channels 1 and 3 holding words
    drive(1'b1, 2'd1, 32'hA5A5A5A5, 4'b0000);
    step();
    drive(1'b1, 2'd3, 32'h5A5A5A5A, 4'b0000);
    step();
    drive(1'b1, 2'd0, 32'h12345678, 4'b0000);
    chk("rst_pre_valid", OUT_VALID, 4'b1010);
    #1;
    CLRN = 1'b0;
    clear_model();
    #1;
    chk("rst_async_valid", OUT_VALID, 4'b0000);
    chk("rst_async_count", COUNT, 16'd0);
    chk("rst_async_in_ready", IN_READY, 1'b0);
    chk("rst_async_y1", Y1, 32'd0);
    chk("rst_async_y3", Y3, 32'd0);
    chk("rst_async_y0", Y0, 32'd0);
    step();
    chk("rst_no_accept", OUT_VALID, 4'b0000);
    CLRN = 1'b1;

    // Counter wrap on the 4-bit instance
    for (int k = 0; k < 17; k++) begin
      drive(1'b1, 2'd0, 32'(k + 100), 4'b0001);
      step();
    end
    drive(1'b0, 2'd0, 32'd0, 4'b0000);
    chk("wrap_count_w4", count_b, 4'd1);
    chk("wrap_count16", COUNT, 16'd17);

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      drive(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom,
            4'($urandom_range(0, 15)));
      step();
    end
    drive(1'b0, 2'd0, 32'd0, 4'b1111);
    repeat (3) step();
    chk("all_drained", OUT_VALID, 4'b0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
